// File: rtl/scalar_lsu.sv
// Scalar load/store unit.
// Takes one memory request at a time from execute and drives a one-cycle
// read or write strobe to the data memory. For loads it captures the
// returned word one cycle later. It then holds a response for writeback
// until that response is consumed.
// Addresses outside the data memory are faulted at acceptance and never
// reach the memory. A saturating counter records each faulted request.
module scalar_lsu #(
    parameter int N       = 24,
    parameter int DMEM_AW = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_address,
    input  logic [N-1:0] req_data,
    input  logic [3:0]   req_rd,
    output logic [N-1:0] scalar_data_address,
    output logic [N-1:0] write_scalar_data,
    output logic         ScalarMemRead,
    output logic         ScalarMemWrite,
    input  logic [N-1:0] scalar_data_read,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_data,
    output logic [3:0]   resp_rd,
    output logic         resp_fault,
    output logic [15:0]  fault_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_r;
    logic           write_r;
    logic [3:0]     tag_r;
    logic [N-1:0]   addr_r;
    logic [N-1:0]   wdata_r;
    logic           mem_rd_r;
    logic           mem_wr_r;
    logic           resp_valid_r;
    logic [N-1:0]   resp_data_r;
    logic [3:0]     resp_rd_r;
    logic           resp_fault_r;
    logic [15:0]    fault_count_r;
    logic           accept_s;
    logic           out_of_range_s;

    // Any set bit above the memory word-address range is a fault.
    function automatic logic addr_out_of_range(input logic [N-1:0] addr);
        return |addr[N-1:DMEM_AW];
    endfunction

    // Ready is decoded from the state. It is gated by rst so that it reads 0
    // while reset is held, and 1 as soon as reset is released.
    assign req_ready      = (state_r == IDLE) && !rst;
    assign accept_s       = req_valid && req_ready;
    assign out_of_range_s = addr_out_of_range(req_address);

    // Request FSM together with all registered memory and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            write_r       <= 1'b0;
            tag_r         <= 4'd0;
            addr_r        <= {N{1'b0}};
            wdata_r       <= {N{1'b0}};
            mem_rd_r      <= 1'b0;
            mem_wr_r      <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= {N{1'b0}};
            resp_rd_r     <= 4'd0;
            resp_fault_r  <= 1'b0;
            fault_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r <= req_write;
                        tag_r   <= req_rd;
                        if (out_of_range_s) begin
                            // A faulted request skips the memory entirely.
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_fault_r <= 1'b1;
                            resp_data_r  <= {N{1'b0}};
                            resp_rd_r    <= req_rd;
                            if (fault_count_r != 16'hFFFF) begin
                                fault_count_r <= fault_count_r + 16'd1;
                            end
                        end else begin
                            state_r  <= ISSUE;
                            addr_r   <= req_address;
                            wdata_r  <= req_data;
                            mem_rd_r <= !req_write;
                            mem_wr_r <= req_write;
                        end
                    end
                end
                ISSUE: begin
                    // The strobe is asserted for exactly this one cycle.
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    if (write_r) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_fault_r <= 1'b0;
                        resp_data_r  <= {N{1'b0}};
                        resp_rd_r    <= tag_r;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // The memory presents the read word during this cycle.
                    state_r      <= RESP;
                    resp_valid_r <= 1'b1;
                    resp_fault_r <= 1'b0;
                    resp_data_r  <= scalar_data_read;
                    resp_rd_r    <= tag_r;
                end
                RESP: begin
                    // No bypass: the state goes back to IDLE first, so the
                    // next request is accepted one cycle later at the earliest.
                    if (resp_ready) begin
                        state_r      <= IDLE;
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign scalar_data_address = addr_r;
    assign write_scalar_data   = wdata_r;
    assign ScalarMemRead       = mem_rd_r;
    assign ScalarMemWrite      = mem_wr_r;
    assign resp_valid          = resp_valid_r;
    assign resp_data           = resp_data_r;
    assign resp_rd             = resp_rd_r;
    assign resp_fault          = resp_fault_r;
    assign fault_count         = fault_count_r;

endmodule

// File: tb/tb_scalar_lsu.sv
// Testbench for scalar_lsu.
// A simple data memory model is attached to the DUT. A reference model
// predicts every response, the latency, the strobe activity and the fault
// count.
module tb_scalar_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_address = 24'd0;
    logic [23:0] req_data = 24'd0;
    logic [3:0]  req_rd = 4'd0;
    logic [23:0] scalar_data_address;
    logic [23:0] write_scalar_data;
    logic        ScalarMemRead;
    logic        ScalarMemWrite;
    bit   [23:0] rd_q;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [23:0] resp_data;
    logic [3:0]  resp_rd;
    logic        resp_fault;
    logic [15:0] fault_count;

    int checks = 0;
    int errors = 0;

    scalar_lsu #(.N(24), .DMEM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .req_rd(req_rd),
        .scalar_data_address(scalar_data_address), .write_scalar_data(write_scalar_data),
        .ScalarMemRead(ScalarMemRead), .ScalarMemWrite(ScalarMemWrite),
        .scalar_data_read(rd_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_fault(resp_fault),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    // Initial memory contents: a fixed address hash, with word 2 = 0x00ABCD.
    function automatic logic [23:0] init_val(input logic [13:0] a);
        logic [23:0] h;
        h = 24'({10'd0, a} * 24'd40503 + 24'h3C6EF3);
        return (a == 14'd2) ? 24'h00ABCD : h;
    endfunction

    // Data memory attached to the DUT: synchronous write, one-cycle read.
    bit [23:0] mem [0:16383];
    bit        mem_written [0:16383];
    // The memory samples the strobes on each rising clock edge.
    always @(posedge clk) begin
        if (ScalarMemWrite === 1'b1) begin
            mem[scalar_data_address[13:0]]         <= write_scalar_data;
            mem_written[scalar_data_address[13:0]] <= 1'b1;
        end
        if (ScalarMemRead === 1'b1) begin
            rd_q <= mem_written[scalar_data_address[13:0]] ? mem[scalar_data_address[13:0]]
                                                             : init_val(scalar_data_address[13:0]);
        end
    end

    function automatic logic [23:0] env_word(input logic [13:0] a);
        return mem_written[a] ? mem[a] : init_val(a);
    endfunction

    // Reference model state.
    logic [23:0] ref_mem [0:16383];
    logic [15:0] model_fc = 16'd0;

    typedef struct {
        int          lat;
        logic [51:0] memv;
        logic [28:0] resp;
        logic [15:0] fc;
    } exp_t;

    // Predicts the outcome of one request and updates the model state.
    // memv holds {strobe count, read, write, address, write data}.
    // resp holds {fault, tag, data}.
    function automatic exp_t predict(input logic wr, input logic [23:0] addr,
                                     input logic [23:0] data, input logic [3:0] tag);
        exp_t e;
        if (addr >= 24'd16384) begin
            e.lat  = 0;
            e.memv = 52'd0;
            e.resp = {1'b1, tag, 24'd0};
            model_fc = (model_fc == 16'hFFFF) ? 16'hFFFF : model_fc + 16'd1;
        end else if (wr) begin
            e.lat  = 1;
            e.memv = {2'd1, 1'b0, 1'b1, addr, data};
            e.resp = {1'b0, tag, 24'd0};
            ref_mem[addr[13:0]] = data;
        end else begin
            e.lat  = 2;
            e.memv = {2'd1, 1'b1, 1'b0, addr, data};
            e.resp = {1'b0, tag, ref_mem[addr[13:0]]};
        end
        e.fc = model_fc;
        return e;
    endfunction

    // What the bench saw during the most recent transaction.
    int          obs_wait;
    int          obs_lat;
    logic [51:0] obs_mem;
    logic [28:0] obs_resp;
    logic [15:0] obs_fc;
    int          obs_hold_bad;
    bit          obs_rel_ok;

    // Runs one request: issue it, watch for the response, stall, then release.
    task automatic do_req(input logic wr, input logic [23:0] addr, input logic [23:0] data,
                          input logic [3:0] tag, input int stall, input bit pulse);
        int n;
        bit got;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        obs_wait = n;
        req_valid = 1'b1; req_write = wr; req_address = addr; req_data = data; req_rd = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_mem = 52'd0;
        obs_lat = -1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            if (ScalarMemRead === 1'b1 || ScalarMemWrite === 1'b1) begin
                if (obs_mem[51:50] != 2'd3) obs_mem[51:50] = obs_mem[51:50] + 2'd1;
                obs_mem[49:0] = {ScalarMemRead, ScalarMemWrite, scalar_data_address, write_scalar_data};
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                obs_lat = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        obs_resp = {resp_fault, resp_rd, resp_data};
        obs_fc = fault_count;
        obs_hold_bad = 0;
        for (int s = 0; s < stall; s++) begin
            if (pulse && s == 1) begin
                req_valid = 1'b1; req_write = 1'b0; req_address = 24'h000001;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || ScalarMemRead !== 1'b0 ||
                ScalarMemWrite !== 1'b0 || {resp_fault, resp_rd, resp_data} !== obs_resp)
                obs_hold_bad++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        obs_rel_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req_ready, ScalarMemRead, ScalarMemWrite, resp_valid, resp_fault, scalar_data_address,
             write_scalar_data, resp_data, resp_rd, fault_count} !== 97'd0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b rd=%b wr=%b rv=%b rf=%b a=%h wd=%h d=%h tag=%h fc=%h, expected all 0",
                     req_ready, ScalarMemRead, ScalarMemWrite, resp_valid, resp_fault,
                     scalar_data_address, write_scalar_data, resp_data, resp_rd, fault_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  wrs = 4'b0010;
        logic [23:0] addrs [4] = '{24'h000002, 24'h000004, 24'h000004, 24'h004000};
        logic [23:0] datas [4] = '{24'h111111, 24'h123456, 24'h222222, 24'h333333};
        logic [3:0]  tags  [4] = '{4'd3, 4'd5, 4'd6, 4'd7};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = predict(wrs[i], addrs[i], datas[i], tags[i]);
            do_req(wrs[i], addrs[i], datas[i], tags[i], 0, 1'b0);
            checks++; if (obs_lat !== e.lat) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, obs_lat, e.lat); end
            checks++; if (obs_mem !== e.memv) begin errors++; $display("FAIL dir_strobe[%0d]: got %h expected %h", i, obs_mem, e.memv); end
            checks++; if (obs_resp !== e.resp) begin errors++; $display("FAIL dir_resp[%0d]: got %h expected %h", i, obs_resp, e.resp); end
            checks++; if (obs_fc !== e.fc) begin errors++; $display("FAIL dir_fault_count[%0d]: got %h expected %h", i, obs_fc, e.fc); end
            checks++; if (!obs_rel_ok) begin errors++; $display("FAIL dir_release[%0d]: got 0 expected 1", i); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int bad;
        e = predict(1'b0, 24'h000004, 24'h0, 4'd9);
        do_req(1'b0, 24'h000004, 24'h0, 4'd9, 5, 1'b1);
        checks++; if (obs_resp !== e.resp) begin errors++; $display("FAIL bp_resp: got %h expected %h", obs_resp, e.resp); end
        checks++; if (obs_hold_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", obs_hold_bad); end
        checks++; if (!obs_rel_ok) begin errors++; $display("FAIL bp_release: got 0 expected 1"); end
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || ScalarMemRead !== 1'b0 || ScalarMemWrite !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_no_queued_req: got %0d busy cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [23:0] a, d;
        for (int i = 0; i < 20; i++) begin
            a = 24'($urandom_range(0, 15));
            d = 24'($urandom);
            e = predict(i[0], a, d, i[3:0]);
            do_req(i[0], a, d, i[3:0], 0, 1'b0);
            checks++; if (obs_wait !== 0) begin errors++; $display("FAIL b2b_wait[%0d]: got %0d expected 0", i, obs_wait); end
            checks++; if (obs_lat !== e.lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, obs_lat, e.lat); end
            checks++; if (obs_resp !== e.resp) begin errors++; $display("FAIL b2b_resp[%0d]: got %h expected %h", i, obs_resp, e.resp); end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic        wr;
        logic [23:0] a, d;
        logic [9:0]  hi;
        int          st;
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            hi = 10'($urandom_range(1, 1023));
            a  = ($urandom_range(0, 7) == 0) ? {hi, 14'($urandom_range(0, 16383))}
                                             : 24'($urandom_range(0, 31));
            d  = 24'($urandom);
            st = $urandom_range(0, 3);
            e = predict(wr, a, d, 4'($urandom_range(0, 15)));
            do_req(wr, a, d, e.resp[27:24], st, 1'b0);
            checks++; if (obs_lat !== e.lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, obs_lat, e.lat); end
            checks++; if (obs_mem !== e.memv) begin errors++; $display("FAIL rnd_strobe[%0d]: got %h expected %h", i, obs_mem, e.memv); end
            checks++; if (obs_resp !== e.resp) begin errors++; $display("FAIL rnd_resp[%0d]: got %h expected %h", i, obs_resp, e.resp); end
            checks++; if (obs_fc !== e.fc) begin errors++; $display("FAIL rnd_fault_count[%0d]: got %h expected %h", i, obs_fc, e.fc); end
            checks++; if (obs_hold_bad !== 0 || !obs_rel_ok) begin errors++; $display("FAIL rnd_hold_release[%0d]: got bad=%0d rel=%b expected 0/1", i, obs_hold_bad, obs_rel_ok); end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [23:0] a, d;
        exp_t e;
        int n, bad;
        a = 24'h000010;
        d = ref_mem[14'd16] ^ 24'hFFFFFF;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_write = 1'b1; req_address = a; req_data = d; req_rd = 4'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (ScalarMemWrite !== 1'b1 || scalar_data_address !== a) begin
            errors++;
            $display("FAIL mid_issue: got wr=%b a=%h expected 1/%h", ScalarMemWrite, scalar_data_address, a);
        end
        #2 rst = 1'b1;
        #1;
        model_fc = 16'd0;
        checks++;
        if ({ScalarMemRead, ScalarMemWrite, resp_valid, resp_fault, req_ready} !== 5'd0 ||
            scalar_data_address !== 24'd0 || fault_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got rd=%b wr=%b rv=%b rf=%b rdy=%b a=%h fc=%h expected all 0",
                     ScalarMemRead, ScalarMemWrite, resp_valid, resp_fault, req_ready, scalar_data_address, fault_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || ScalarMemWrite !== 1'b0 || ScalarMemRead !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_abandon: got %0d active cycles expected 0", bad); end
        checks++; if (env_word(14'd16) !== ref_mem[14'd16]) begin errors++; $display("FAIL mid_mem_unchanged: got %h expected %h", env_word(14'd16), ref_mem[14'd16]); end
        e = predict(1'b0, a, 24'd0, 4'd2);
        do_req(1'b0, a, 24'd0, 4'd2, 0, 1'b0);
        checks++; if (obs_resp !== e.resp) begin errors++; $display("FAIL mid_reload: got %h expected %h", obs_resp, e.resp); end
    endtask

    task automatic test_saturation();
        exp_t e;
        dut.fault_count_r = 16'hFFFD;
        model_fc = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            e = predict(1'b0, 24'hFFC000, 24'd0, 4'd4);
            do_req(1'b0, 24'hFFC000, 24'd0, 4'd4, 0, 1'b0);
            checks++; if (obs_fc !== e.fc) begin errors++; $display("FAIL sat_fault_count[%0d]: got %h expected %h", i, obs_fc, e.fc); end
            checks++; if (obs_resp !== e.resp || obs_mem !== 52'd0) begin errors++; $display("FAIL sat_resp[%0d]: got %h/%h expected %h/0", i, obs_resp, obs_mem, e.resp); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(14'(i));
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_lsu.md
SCALAR_LSU -- requirements
Module: scalar_lsu

Interface
REQ-001 Parameter: N, default 24, data/address word width in bits.
REQ-002 Parameter: DMEM_AW, default 14, data memory word-address width (16384 words).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  execute stage presents a memory request.
REQ-007 req_ready  out  1  LSU can accept a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_address  in  N  word address (ALUResult).
REQ-010 req_data  in  N  store data (register file RD2).
REQ-011 req_rd  in  4  destination register tag, returned with the response.
REQ-012 scalar_data_address  out  N  to data memory A.
REQ-013 write_scalar_data  out  N  to data memory WD.
REQ-014 ScalarMemRead  out  1  data memory read strobe.
REQ-015 ScalarMemWrite  out  1  data memory write strobe.
REQ-016 scalar_data_read  in  N  data memory RD; valid one cycle after the sampled read.
REQ-017 resp_valid  out  1  response available to writeback.
REQ-018 resp_ready  in  1  writeback accepts the response.
REQ-019 resp_data  out  N  load data; 0 for stores and faults.
REQ-020 resp_rd  out  4  tag of the completed request.
REQ-021 resp_fault  out  1  request address out of range.
REQ-022 fault_count  out  16  saturating count of faulted requests.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-024 Accept on rising edge with req_valid && req_ready; capture write, address, data, tag into internal registers.
REQ-025 Fault check at acceptance: req_address[N-1:DMEM_AW] != 0 SHALL fault; fault goes IDLE->RESP, resp_fault=1, resp_data=0, no strobe ever asserted.
REQ-026 Non-faulting request SHALL go IDLE->ISSUE; ISSUE SHALL last exactly one cycle.
REQ-027 In ISSUE: scalar_data_address=captured address; ScalarMemRead=!write; ScalarMemWrite=write; write_scalar_data=captured data.
REQ-028 Strobes SHALL be 0 in every state other than ISSUE; address/write data SHALL hold their last values.
REQ-029 Store: ISSUE->RESP; resp_valid asserted from the edge after ISSUE (1 cycle after acceptance edge).
REQ-030 Load: ISSUE->WAIT->RESP; resp_data SHALL capture scalar_data_read at WAIT-exit edge; resp_valid from 2 cycles after acceptance edge.
REQ-031 RESP: resp_valid, resp_data, resp_rd, resp_fault SHALL hold stable until resp_valid && resp_ready, then go IDLE and drop resp_valid next cycle.
REQ-032 No request SHALL be accepted in the cycle a response is consumed (no bypass); next accept earliest one cycle later.
REQ-033 fault_count SHALL increment by 1 on each faulted acceptance and saturate at 0xFFFF.
REQ-034 req_valid deasserting while not ready SHALL have no effect; no request is queued.

Reset
REQ-035 rst high SHALL immediately (asynchronously) force: state IDLE, ScalarMemRead=0, ScalarMemWrite=0, resp_valid=0, resp_fault=0.
REQ-036 Reset values: scalar_data_address=0, write_scalar_data=0, resp_data=0, resp_rd=0, fault_count=0; req_ready=0 while rst high, 1 from first cycle after release.
REQ-037 Reset mid-operation SHALL abandon the request; no strobe or response for it after rst asserts.

Verification
REQ-038 Load addr 0x000002, memory word 0x00ABCD, tag 3 -> ScalarMemRead=1 one cycle, address 0x000002; resp_valid 2 cycles after accept, resp_data=0x00ABCD, resp_rd=3, resp_fault=0.
REQ-039 Store addr 0x000004 data 0x123456 -> ScalarMemWrite=1 exactly one cycle, WD=0x123456; ack 1 cycle after accept, resp_data=0; subsequent load 0x000004 returns 0x123456.
REQ-040 Load addr 0x004000 -> no strobe, resp_fault=1, resp_data=0, fault_count 0->1.
REQ-041 resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0 throughout; resp_ready=1 -> IDLE, new request accepted one cycle later.
REQ-042 rst asserted during ISSUE of a store -> ScalarMemWrite falls immediately, no response, memory word unchanged.
REQ-043 fault_count preset by 65536 faulted requests -> holds 0xFFFF on further faults.
